// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//   Steps a small stored program through an external accumulator ALU. Each
//   program slot holds {mode, A, B}. A run clears the ALU once, then for each
//   slot issues the operation for one cycle and captures the ALU result and
//   error code on the following cycle. The run can optionally stop at the
//   first nonzero ALU error.
//
// Ports
//   clk           single clock, rising edge
//   reset         synchronous, active-low reset
//   prog_we       program-slot write strobe (honoured in IDLE only)
//   prog_addr     slot to write
//   prog_data     {mode, A, B}, mode in the MSBs, B in the LSBs
//   prog_len      number of slots to run (clamped to DEPTH), latched at start
//   start         run request (ignored unless IDLE)
//   abort_on_err  stop the run at the first nonzero ALU error, latched at start
//   alu_out       ALU accumulator output
//   alu_error     ALU error code (00 none, 01 overflow, 10 underflow)
//   alu_mode      function code to the ALU (0 = NoChange)
//   alu_inA       operand A to the ALU
//   alu_inB       operand B to the ALU
//   alu_clear     ALU accumulator clear
//   busy          run in progress (CLEAR, ISSUE, CAPTURE)
//   done          one-cycle run-complete pulse
//   result        last captured alu_out
//   err_flag      OR of all alu_error values captured in the run
//   err_step      slot index of the first nonzero error, 0 if none
// -----------------------------------------------------------------------------
module alu_sequencer #(
  parameter int DATALEN  = 8,
  parameter int MODELEN  = 4,
  parameter int ERRORLEN = 2,
  parameter int DEPTH    = 8,
  localparam int AW      = $clog2(DEPTH),
  localparam int PW      = MODELEN + 2*DATALEN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                prog_we,
  input  logic [AW-1:0]       prog_addr,
  input  logic [PW-1:0]       prog_data,
  input  logic [3:0]          prog_len,
  input  logic                start,
  input  logic                abort_on_err,
  input  logic [DATALEN-1:0]  alu_out,
  input  logic [ERRORLEN-1:0] alu_error,
  output logic [MODELEN-1:0]  alu_mode,
  output logic [DATALEN-1:0]  alu_inA,
  output logic [DATALEN-1:0]  alu_inB,
  output logic                alu_clear,
  output logic                busy,
  output logic                done,
  output logic [DATALEN-1:0]  result,
  output logic [ERRORLEN-1:0] err_flag,
  output logic [AW-1:0]       err_step
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, ISSUE, CAPTURE, DONE
  } state_t;

  localparam logic [3:0] MAXLEN = 4'(DEPTH);

  state_t              state, state_nx;
  logic [AW-1:0]       step;
  logic [3:0]          len_q;
  logic                abort_q;
  logic [PW-1:0]       mem [DEPTH];
  logic [PW-1:0]       slot;
  logic [3:0]          eff_len;
  logic                last_step;
  logic                err_now;
  logic                finish_run;

  assign eff_len    = (prog_len > MAXLEN) ? MAXLEN : prog_len;
  assign slot       = mem[step];
  assign last_step  = (4'(step) == len_q - 4'd1);
  assign err_now    = (alu_error != '0);
  assign finish_run = last_step || (abort_q && err_now);

  // NOTE: program memory has no reset so it keeps its contents across a
  // reset and maps onto plain storage; only control state is reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && prog_we)
      mem[prog_addr] <= prog_data;
  end

  // NOTE: every clocked assignment is non-blocking so all registers update
  // from the same pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      step     <= '0;
      len_q    <= '0;
      abort_q  <= 1'b0;
      result   <= '0;
      err_flag <= '0;
      err_step <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            // Length and abort policy are frozen for the whole run.
            step     <= '0;
            err_flag <= '0;
            err_step <= '0;
            len_q    <= eff_len;
            abort_q  <= abort_on_err;
          end
        end
        CAPTURE: begin
          result   <= alu_out;
          err_flag <= err_flag | alu_error;
          // Only the first erroring slot of the run is recorded.
          if (err_now && err_flag == '0)
            err_step <= step;
          if (!finish_run)
            step <= step + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    done      = 1'b0;
    alu_clear = 1'b0;
    alu_mode  = '0;
    alu_inA   = '0;
    alu_inB   = '0;
    case (state)
      IDLE: begin
        if (start)
          state_nx = (eff_len != 4'd0) ? CLEAR : DONE;
      end
      CLEAR: begin
        busy      = 1'b1;
        alu_clear = 1'b1;
        state_nx  = ISSUE;
      end
      ISSUE: begin
        busy                        = 1'b1;
        {alu_mode, alu_inA, alu_inB} = slot;
        state_nx                    = CAPTURE;
      end
      CAPTURE: begin
        busy     = 1'b1;
        state_nx = finish_run ? DONE : ISSUE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//   Directed bench for alu_sequencer with a small accumulator ALU model.
//   Cycle k is the clock period following rising edge k-1; start is sampled
//   at edge 0. Inputs change and outputs are sampled on the falling edge.
//   ALU model modes: 0 NoChange, 1 NOT, 2 ADD A (overflow 01),
//   3 SUB A (underflow 10), 4 LOAD A.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        prog_we = 1'b0;
  logic [2:0]  prog_addr = '0;
  logic [19:0] prog_data = '0;
  logic [3:0]  prog_len = '0;
  logic        start = 1'b0;
  logic        abort_on_err = 1'b0;
  logic [7:0]  alu_out;
  logic [1:0]  alu_error;
  logic [3:0]  alu_mode;
  logic [7:0]  alu_inA, alu_inB;
  logic        alu_clear, busy, done;
  logic [7:0]  result;
  logic [1:0]  err_flag;
  logic [2:0]  err_step;

  alu_sequencer dut (
    .clk(clk), .reset(reset),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_len(prog_len), .start(start), .abort_on_err(abort_on_err),
    .alu_out(alu_out), .alu_error(alu_error),
    .alu_mode(alu_mode), .alu_inA(alu_inA), .alu_inB(alu_inB),
    .alu_clear(alu_clear), .busy(busy), .done(done),
    .result(result), .err_flag(err_flag), .err_step(err_step)
  );

  always #5 clk = ~clk;

  // Accumulator ALU model
  logic [7:0] acc  = '0;
  logic [1:0] aerr = '0;
  always @(posedge clk) begin
    if (alu_clear) begin
      acc  <= '0;
      aerr <= '0;
    end else begin
      case (alu_mode)
        4'd1: begin acc <= ~acc;          aerr <= 2'b00; end
        4'd2: begin acc <= acc + alu_inA;
                    aerr <= (({1'b0, acc} + {1'b0, alu_inA}) > 9'h0FF) ? 2'b01 : 2'b00; end
        4'd3: begin acc <= acc - alu_inA; aerr <= (alu_inA > acc) ? 2'b10 : 2'b00; end
        4'd4: begin acc <= alu_inA;       aerr <= 2'b00; end
        default: ;
      endcase
    end
  end
  assign alu_out   = acc;
  assign alu_error = aerr;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-run observations
  int         done_cyc, n_clear, clear_cyc, n_issue, busy_seen;
  int         issue_cyc[$];
  logic [3:0] issue_mode[$];
  logic [7:0] issue_a[$];
  int         poke_cyc = 0;
  int         rst_cyc  = 0;
  logic [19:0] poke_data = '0;

  function automatic logic [19:0] op(input logic [3:0] m, input logic [7:0] a);
    return {m, a, 8'h00};
  endfunction

  task automatic write_slot(input logic [2:0] addr, input logic [19:0] data);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = addr; prog_data = data;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Starts a run (optionally writing slot 0 in the same cycle) and watches it
  // until done, a mid-run reset has been observed, or the budget expires.
  // prog_len/abort_on_err are scrambled right after the start edge.
  task automatic run_job(input logic [3:0] len, input logic abort,
                         input bit wr0, input logic [19:0] wdata, input int budget);
    int cyc;
    bit stop;
    done_cyc = -1; n_clear = 0; clear_cyc = -1; n_issue = 0; busy_seen = 0;
    issue_cyc.delete(); issue_mode.delete(); issue_a.delete();
    @(negedge clk);
    prog_len = len; abort_on_err = abort; start = 1'b1;
    if (wr0) begin prog_we = 1'b1; prog_addr = 3'd0; prog_data = wdata; end
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0; prog_len = 4'd1; abort_on_err = ~abort;
    cyc = 1; stop = 0;
    while (!stop && cyc <= budget) begin
      if (busy) busy_seen = 1;
      if (alu_clear) begin n_clear++; if (clear_cyc < 0) clear_cyc = cyc; end
      if (alu_mode != 4'd0) begin
        n_issue++;
        issue_cyc.push_back(cyc); issue_mode.push_back(alu_mode); issue_a.push_back(alu_inA);
      end
      if (done) begin
        done_cyc = cyc; stop = 1;
      end else if (rst_cyc > 0 && cyc == rst_cyc + 1) begin
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_clear", alu_clear, 0);
        check("rst_mode", alu_mode, 0);
        check("rst_inA", alu_inA, 0);
        check("rst_inB", alu_inB, 0);
        check("rst_result", result, 0);
        check("rst_err_flag", err_flag, 0);
        check("rst_err_step", err_step, 0);
        reset = 1'b1; stop = 1;
      end
      if (!stop) begin
        if (rst_cyc > 0 && cyc == rst_cyc) reset = 1'b0;
        if (poke_cyc > 0 && cyc == poke_cyc) begin
          start = 1'b1; prog_we = 1'b1; prog_addr = 3'd0; prog_data = poke_data;
        end else if (poke_cyc > 0 && cyc == poke_cyc + 1) begin
          start = 1'b0; prog_we = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0; prog_we = 1'b0;
  endtask

  initial begin
    int idle_busy;

    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_clear", alu_clear, 0);
    check("reset_mode", alu_mode, 0);
    check("reset_result", result, 0);
    check("reset_err_flag", err_flag, 0);
    check("reset_err_step", err_step, 0);
    reset = 1'b1;

    // Two-slot run: LOAD 0x51, NOT -> 0xAE
    write_slot(3'd0, op(4'd4, 8'h51));
    write_slot(3'd1, op(4'd1, 8'h00));
    run_job(4'd2, 1'b0, 0, '0, 40);
    check("two_done_cyc", done_cyc, 6);
    check("two_clear_cyc", clear_cyc, 1);
    check("two_n_clear", n_clear, 1);
    check("two_n_issue", n_issue, 2);
    check("two_issue0_cyc", issue_cyc[0], 2);
    check("two_issue0_mode", issue_mode[0], 4);
    check("two_issue0_a", issue_a[0], 8'h51);
    check("two_issue1_cyc", issue_cyc[1], 4);
    check("two_issue1_mode", issue_mode[1], 1);
    check("two_result", result, 8'hAE);
    check("two_err_flag", err_flag, 0);
    check("two_done_busy", busy, 0);
    @(negedge clk);
    check("two_done_pulse", done, 0);

    // Zero-length run
    run_job(4'd0, 1'b0, 0, '0, 20);
    check("zero_done_cyc", done_cyc, 1);
    check("zero_busy", busy_seen, 0);
    check("zero_clear", n_clear, 0);
    check("zero_issue", n_issue, 0);
    check("zero_result", result, 8'hAE);

    // Error run: LOAD F0, ADD 20 (overflow), LOAD 33
    write_slot(3'd0, op(4'd4, 8'hF0));
    write_slot(3'd1, op(4'd2, 8'h20));
    write_slot(3'd2, op(4'd4, 8'h33));
    run_job(4'd3, 1'b1, 0, '0, 40);
    check("abort_done_cyc", done_cyc, 6);
    check("abort_err_flag", err_flag, 2'b01);
    check("abort_err_step", err_step, 1);
    check("abort_n_issue", n_issue, 2);
    check("abort_result", result, 8'h10);
    run_job(4'd3, 1'b0, 0, '0, 40);
    check("noabort_done_cyc", done_cyc, 8);
    check("noabort_err_flag", err_flag, 2'b01);
    check("noabort_err_step", err_step, 1);
    check("noabort_n_issue", n_issue, 3);
    check("noabort_result", result, 8'h33);

    // Accumulated errors: LOAD 05, SUB 10 (underflow), ADD 20 (overflow)
    write_slot(3'd0, op(4'd4, 8'h05));
    write_slot(3'd1, op(4'd3, 8'h10));
    write_slot(3'd2, op(4'd2, 8'h20));
    run_job(4'd3, 1'b0, 0, '0, 40);
    check("mix_done_cyc", done_cyc, 8);
    check("mix_err_flag", err_flag, 2'b11);
    check("mix_err_step", err_step, 1);
    check("mix_result", result, 8'h15);

    // start and prog_we in cycle 3 of a run are ignored
    write_slot(3'd0, op(4'd4, 8'h51));
    write_slot(3'd1, op(4'd1, 8'h00));
    poke_cyc = 3; poke_data = op(4'd4, 8'h99);
    run_job(4'd2, 1'b0, 0, '0, 40);
    poke_cyc = 0;
    check("poke_done_cyc", done_cyc, 6);
    check("poke_result", result, 8'hAE);
    check("poke_n_issue", n_issue, 2);
    idle_busy = 0;
    repeat (4) begin @(negedge clk); if (busy || done) idle_busy = 1; end
    check("poke_no_queue", idle_busy, 0);
    run_job(4'd2, 1'b0, 0, '0, 40);
    check("poke_slot0_a", issue_a[0], 8'h51);
    check("poke_rerun_result", result, 8'hAE);

    // Reset in cycle 3 of a 4-slot run, then re-run the retained program
    write_slot(3'd0, op(4'd4, 8'h10));
    write_slot(3'd1, op(4'd2, 8'h05));
    write_slot(3'd2, op(4'd1, 8'h00));
    write_slot(3'd3, op(4'd2, 8'h01));
    rst_cyc = 3;
    run_job(4'd4, 1'b0, 0, '0, 40);
    rst_cyc = 0;
    check("rst_no_done", done_cyc, -1);
    run_job(4'd4, 1'b0, 0, '0, 40);
    check("rerun_done_cyc", done_cyc, 10);
    check("rerun_result", result, 8'hEB);
    check("rerun_n_issue", n_issue, 4);

    // prog_len=12 is clamped to 8 slots
    write_slot(3'd0, op(4'd4, 8'h01));
    for (int i = 1; i < 8; i++) write_slot(3'(i), op(4'd2, 8'h02));
    run_job(4'd12, 1'b0, 0, '0, 60);
    check("len12_n_issue", n_issue, 8);
    check("len12_done_cyc", done_cyc, 18);
    check("len12_n_clear", n_clear, 1);
    check("len12_result", result, 8'h0F);

    // Write and start in the same IDLE cycle
    run_job(4'd1, 1'b0, 1, op(4'd4, 8'h20), 20);
    check("wrstart_done_cyc", done_cyc, 4);
    check("wrstart_issue_a", issue_a[0], 8'h20);
    check("wrstart_result", result, 8'h20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter DATALEN, default 8, ALU operand/result width.
REQ-002 Parameter MODELEN, default 4, ALU function-code width.
REQ-003 Parameter ERRORLEN, default 2, ALU error-code width.
REQ-004 Parameter DEPTH, default 8, program slots (address width 3).
REQ-005 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-006 reset  in  1  reset, synchronous, active-low.
REQ-007 prog_we  in  1  program-slot write strobe.
REQ-008 prog_addr  in  3  slot to write.
REQ-009 prog_data  in  MODELEN+2*DATALEN  {mode, A, B}; mode in the MSBs, B in the LSBs.
REQ-010 prog_len  in  4  number of slots to execute, 0..15.
REQ-011 start  in  1  run request.
REQ-012 abort_on_err  in  1  stop the run at the first nonzero ALU error.
REQ-013 alu_out  in  DATALEN  ALU accumulator output.
REQ-014 alu_error  in  ERRORLEN  ALU error code (00 none, 01 overflow, 10 underflow).
REQ-015 alu_mode  out  MODELEN  function code to the ALU.
REQ-016 alu_inA  out  DATALEN  operand A to the ALU.
REQ-017 alu_inB  out  DATALEN  operand B to the ALU.
REQ-018 alu_clear  out  1  ALU accumulator clear.
REQ-019 busy  out  1  run in progress.
REQ-020 done  out  1  one-cycle run-complete pulse.
REQ-021 result  out  DATALEN  last captured alu_out.
REQ-022 err_flag  out  ERRORLEN  bitwise OR of all captured alu_error values in the run.
REQ-023 err_step  out  3  slot index of the first nonzero error; 0 if there was none.

Function
REQ-024 FSM states SHALL be IDLE, CLEAR, ISSUE, CAPTURE and DONE; the step counter SHALL be 3 bits.
REQ-025 IDLE: start=1 SHALL go to CLEAR if the effective length is nonzero, else to DONE; clear err_flag, err_step and step.
- Effective length = min(prog_len, 8).
REQ-026 CLEAR: alu_clear=1 and alu_mode=0000 for exactly one cycle, then ISSUE.
REQ-027 ISSUE: drive alu_mode/alu_inA/alu_inB from slot[step] for exactly one cycle, then CAPTURE.
REQ-028 CAPTURE: alu_mode=0000 (NoChange); register alu_out into result.
- err_flag |= alu_error.
- If alu_error!=0 and err_flag was 00, err_step=step.
REQ-029 CAPTURE exit: go to DONE if step = length-1, or if abort_on_err=1 and alu_error!=0; otherwise step++ and go to ISSUE.
REQ-030 DONE: done=1 for exactly one cycle, then IDLE.
REQ-031 busy SHALL be 1 in CLEAR, ISSUE and CAPTURE only.
REQ-032 Outside CLEAR, alu_clear SHALL be 0; outside ISSUE, alu_mode=0000 and alu_inA=alu_inB=0.
REQ-033 Latency: with start sampled at edge 0, done SHALL be high in cycle 2+2*len.
REQ-034 A zero-length run SHALL raise done in cycle 1, with no ALU activity and result unchanged.
REQ-035 start while not in IDLE SHALL be ignored; there is no queuing.
REQ-036 prog_we SHALL write only in IDLE and be ignored otherwise.
- A write and a start in the same IDLE cycle SHALL both take effect.
- The run SHALL execute the newly written data.
REQ-037 prog_len and abort_on_err SHALL be latched at the start-accept edge; later changes SHALL have no effect on the run.
REQ-038 Program memory SHALL be DEPTH x (MODELEN+2*DATALEN) registers with no combinational path from prog_data to the alu_* outputs.

Reset
REQ-039 With reset=0 at a rising edge, the FSM SHALL enter IDLE regardless of state, including mid-run.
- busy=done=alu_clear=0, alu_mode=0000, alu_inA=alu_inB=0, result=0, err_flag=00, err_step=0, step=0.
REQ-040 Reset SHALL NOT clear program memory; contents are retained.
REQ-041 A reset mid-run SHALL NOT produce a done pulse.

Verification
REQ-042 Two-slot run: slot0={0100,0x51,0x00} (Load), slot1={0001,0x00,0x00} (NOT), prog_len=2, start at edge 0.
- alu_clear high in cycle 1; Load issued in cycle 2; NOT issued in cycle 4.
- done in cycle 6 with result=0xAE and err_flag=00.
REQ-043 prog_len=0, start -> done in cycle 1; busy never high; alu_clear never high; result keeps its prior value.
REQ-044 Error run: prog_len=3, abort_on_err=1, bench ALU model returns alu_error=01 at slot 1.
- done in cycle 6; err_flag=01; err_step=1; slot 2 never issued.
- Repeat with abort_on_err=0: done in cycle 8; err_flag=01.
REQ-045 start pulsed again in cycle 3 of a running job, and prog_we in cycle 3 to slot0 -> both ignored; run completes unchanged; slot0 contents unchanged.
REQ-046 reset=0 in cycle 3 of a 4-slot run.
- Next cycle: IDLE, all outputs at reset values, no done pulse.
- A new start then re-executes the retained program and produces the same result as an undisturbed run.
REQ-047 prog_len=12 -> exactly 8 ISSUE cycles; done in cycle 18.
